// File: rtl/shift_pkg.sv
// Shared constants and word type for the shifter and the CORDIC stages.
// The CORDIC stages scale their operands with the variable-shift primitive.
package shift_pkg;

  localparam int DEF_WORD_WIDTH  = 16;
  localparam int DEF_SHIFT_WIDTH = 4;

  typedef logic signed [DEF_WORD_WIDTH-1:0] word_t;

endpackage

// File: rtl/shift_right_stage.sv
// One barrel level: when en=1, arithmetic right shift by the constant
// STAGE_SHIFT; otherwise pass-through.
module shift_right_stage
  import shift_pkg::*;
#(
  parameter int WORD_WIDTH  = DEF_WORD_WIDTH,
  parameter int STAGE_SHIFT = 1
) (
  input  logic                  en,
  input  logic [WORD_WIDTH-1:0] data_in,
  output logic [WORD_WIDTH-1:0] data_out
);

  logic [WORD_WIDTH-1:0] shifted_s;

  // Shifts that reach the full word width leave nothing but sign bits.
  if (STAGE_SHIFT >= WORD_WIDTH) begin : g_fill
    assign shifted_s = {WORD_WIDTH{data_in[WORD_WIDTH-1]}};
  end else begin : g_shift
    assign shifted_s = {{STAGE_SHIFT{data_in[WORD_WIDTH-1]}},
                        data_in[WORD_WIDTH-1:STAGE_SHIFT]};
  end

  // Select the shifted or the unshifted word.
  always_comb begin
    data_out = data_in;
    if (en) begin
      data_out = shifted_s;
    end else begin
      data_out = data_in;
    end
  end

endmodule

// File: rtl/shift_right_var.sv
// Registered arithmetic right shifter with a run-time shift amount, built as
// a logarithmic barrel of constant-shift stages followed by one register.
module shift_right_var
  import shift_pkg::*;
#(
  parameter int WORD_WIDTH  = DEF_WORD_WIDTH,
  parameter int SHIFT_WIDTH = DEF_SHIFT_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  input  logic [WORD_WIDTH-1:0]  data_in,
  input  logic [SHIFT_WIDTH-1:0] shift_amount,
  output logic                   out_valid,
  output logic [WORD_WIDTH-1:0]  data_out
);

  logic [WORD_WIDTH-1:0] barrel_s;

  // Stage k shifts by 2^k, so any amount 0..2^SHIFT_WIDTH-1 is a sum of stages.
  for (genvar k = 0; k < SHIFT_WIDTH; k++) begin : g_stage
    logic [WORD_WIDTH-1:0] in_s;
    logic [WORD_WIDTH-1:0] out_s;

    if (k == 0) begin : g_first
      assign in_s = data_in;
    end else begin : g_next
      assign in_s = g_stage[k-1].out_s;
    end

    shift_right_stage #(
      .WORD_WIDTH  (WORD_WIDTH),
      .STAGE_SHIFT (1 << k)
    ) u_stage (
      .en       (shift_amount[k]),
      .data_in  (in_s),
      .data_out (out_s)
    );
  end

  assign barrel_s = g_stage[SHIFT_WIDTH-1].out_s;

  // Output register; data holds across idle cycles, valid tracks the input.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_out  <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        data_out <= barrel_s;
      end else begin
        data_out <= data_out;
      end
    end
  end

endmodule

// File: tb/tb_shift_right_var.sv
// Self-checking bench for shift_right_var: directed table, reset sequences
// and a random sweep against a floor-divide reference model.
module tb_shift_right_var;

  localparam int WW = 16;
  localparam int SW = 5;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 in_valid;
  logic signed [WW-1:0] data_in;
  logic [SW-1:0]        shift_amount;
  logic                 out_valid;
  logic signed [WW-1:0] data_out;

  int vec_count = 0;
  int miscompares = 0;

  typedef struct {
    logic                 v;
    logic signed [WW-1:0] d;
    logic [SW-1:0]        s;
    logic                 exp_v;
    logic signed [WW-1:0] exp_d;
  } vec_t;

  vec_t tbl [14];

  shift_right_var #(.WORD_WIDTH(WW), .SHIFT_WIDTH(SW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .data_in      (data_in),
    .shift_amount (shift_amount),
    .out_valid    (out_valid),
    .data_out     (data_out)
  );

  always #5 clk = ~clk;

  task automatic apply(input logic v, input logic signed [WW-1:0] d, input logic [SW-1:0] s);
    in_valid     = v;
    data_in      = d;
    shift_amount = s;
    @(posedge clk);
    #1;
    vec_count++;
  endtask

  task automatic check(input string name, input logic exp_v, input logic signed [WW-1:0] exp_d);
    if (out_valid !== exp_v || data_out !== exp_d) begin
      miscompares++;
      $display("FAIL %s: got valid=%0b data=%0d, expected valid=%0b data=%0d",
               name, out_valid, data_out, exp_v, exp_d);
    end
  endtask

  // Reference: floor(d / 2^s) using plain integer arithmetic.
  function automatic logic signed [WW-1:0] ref_shift(input logic signed [WW-1:0] d, input int s);
    longint num;
    longint den;
    longint q;
    num = longint'(d);
    den = longint'(1) << s;
    q   = num / den;
    if (num < 0 && (num % den) != 0) q = q - 1;
    return WW'(q);
  endfunction

  initial begin
    logic signed [WW-1:0] model_d;
    logic                 rv;
    logic signed [WW-1:0] rd;
    int                   rs;

    tbl[0]  = '{1'b1, 16'sd597,    5'd3,  1'b1, 16'sd74};
    tbl[1]  = '{1'b1, 16'sd597,    5'd1,  1'b1, 16'sd298};
    tbl[2]  = '{1'b1, 16'sd16,     5'd2,  1'b1, 16'sd4};
    tbl[3]  = '{1'b1, -16'sd597,   5'd3,  1'b1, -16'sd75};
    tbl[4]  = '{1'b1, -16'sd1,     5'd5,  1'b1, -16'sd1};
    tbl[5]  = '{1'b1, -16'sd16,    5'd2,  1'b1, -16'sd4};
    tbl[6]  = '{1'b1, -16'sd32768, 5'd15, 1'b1, -16'sd1};
    tbl[7]  = '{1'b1, 16'sd32767,  5'd15, 1'b1, 16'sd0};
    tbl[8]  = '{1'b1, 16'sd597,    5'd0,  1'b1, 16'sd597};
    tbl[9]  = '{1'b1, 16'sd597,    5'd20, 1'b1, 16'sd0};
    tbl[10] = '{1'b1, -16'sd597,   5'd31, 1'b1, -16'sd1};
    tbl[11] = '{1'b1, 16'sd597,    5'd3,  1'b1, 16'sd74};
    tbl[12] = '{1'b0, 16'sd16,     5'd2,  1'b0, 16'sd74};
    tbl[13] = '{1'b1, 16'sd16,     5'd2,  1'b1, 16'sd4};

    // Reset held for two edges with valid traffic present.
    rst_n = 1'b0;
    apply(1'b1, 16'sd597, 5'd3);
    check("reset_cycle1", 1'b0, 16'sd0);
    apply(1'b1, 16'sd597, 5'd3);
    check("reset_cycle2", 1'b0, 16'sd0);
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      apply(tbl[i].v, tbl[i].d, tbl[i].s);
      check($sformatf("table[%0d]", i), tbl[i].exp_v, tbl[i].exp_d);
    end

    // Reset mid-stream discards the in-flight result.
    apply(1'b1, 16'sd597, 5'd1);
    check("pre_midreset", 1'b1, 16'sd298);
    rst_n = 1'b0;
    apply(1'b1, -16'sd597, 5'd3);
    check("midreset", 1'b0, 16'sd0);
    rst_n = 1'b1;
    apply(1'b0, 16'sd100, 5'd1);
    check("post_midreset_idle", 1'b0, 16'sd0);
    apply(1'b1, -16'sd597, 5'd3);
    check("post_midreset_first", 1'b1, -16'sd75);

    // Random sweep: every shift amount, random data, occasional idle cycles.
    model_d = -16'sd75;
    for (int i = 0; i < 1200; i++) begin
      rv = ($urandom_range(0, 7) != 0);
      rd = WW'($urandom);
      rs = (i < 64) ? (i % 32) : int'($urandom_range(0, 31));
      if (i % 97 == 5) rd = -16'sd32768;
      if (rv) model_d = ref_shift(rd, rs);
      apply(rv, rd, SW'(rs));
      check($sformatf("random[%0d] d=%0d s=%0d", i, rd, rs), rv, model_d);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule
